// File: rtl/hack_cpu16.sv
// Single-cycle Hack CPU core: A/D/PC registers, Hack ALU, jump logic and memory buses.
// Two 16-bit selectors choose the A-register source and the ALU y operand.

module hack_cpu16_mux16 (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   input  logic        sel_i,
   output logic [15:0] y_o
);

   // Two-way select: sel_i picks b_i
   always_comb begin
      if (sel_i) begin
         y_o = b_i;
      end else begin
         y_o = a_i;
      end
   end

endmodule

module hack_cpu16 #(
   parameter int WIDTH = 16,
   parameter int PC_W  = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] instruction,
   input  logic [WIDTH-1:0] inM,
   output logic [WIDTH-1:0] outM,
   output logic             writeM,
   output logic [PC_W-1:0]  addressM,
   output logic [PC_W-1:0]  pc
);

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [PC_W-1:0]  pc_q, pc_d;

   logic             is_c_s;
   logic             a_bit_s;
   logic             zx_s, nx_s, zy_s, ny_s, f_s, no_s;
   logic             dest_a_s, dest_d_s, dest_m_s;
   logic [2:0]       jmp_s;
   logic [WIDTH-1:0] y_sel_s;
   logic [WIDTH-1:0] a_src_s;
   logic [WIDTH-1:0] alu_x_s, alu_y_s, alu_r_s;
   logic             zr_s, ng_s, jump_s;
   logic             unused_bits_s;

   assign is_c_s   = instruction[15];
   assign a_bit_s  = instruction[12];
   assign zx_s     = instruction[11];
   assign nx_s     = instruction[10];
   assign zy_s     = instruction[9];
   assign ny_s     = instruction[8];
   assign f_s      = instruction[7];
   assign no_s     = instruction[6];
   assign dest_a_s = instruction[5];
   assign dest_d_s = instruction[4];
   assign dest_m_s = instruction[3];
   assign jmp_s    = instruction[2:0];
   assign unused_bits_s = &{1'b0, instruction[14:13]};

   hack_cpu16_mux16 u_y_mux (
      .a_i   (a_q),
      .b_i   (inM),
      .sel_i (a_bit_s),
      .y_o   (y_sel_s)
   );

   hack_cpu16_mux16 u_a_mux (
      .a_i   (instruction),
      .b_i   (alu_r_s),
      .sel_i (is_c_s),
      .y_o   (a_src_s)
   );

   // Hack ALU; decoded from the instruction bits even for A-instructions
   always_comb begin
      alu_x_s = d_q;
      alu_y_s = y_sel_s;
      alu_r_s = {WIDTH{1'b0}};
      if (zx_s) begin
         alu_x_s = {WIDTH{1'b0}};
      end else begin
         alu_x_s = d_q;
      end
      if (nx_s) begin
         alu_x_s = ~alu_x_s;
      end else begin
         alu_x_s = alu_x_s;
      end
      if (zy_s) begin
         alu_y_s = {WIDTH{1'b0}};
      end else begin
         alu_y_s = y_sel_s;
      end
      if (ny_s) begin
         alu_y_s = ~alu_y_s;
      end else begin
         alu_y_s = alu_y_s;
      end
      if (f_s) begin
         alu_r_s = alu_x_s + alu_y_s;
      end else begin
         alu_r_s = alu_x_s & alu_y_s;
      end
      if (no_s) begin
         alu_r_s = ~alu_r_s;
      end else begin
         alu_r_s = alu_r_s;
      end
   end

   assign zr_s   = (alu_r_s == {WIDTH{1'b0}});
   assign ng_s   = alu_r_s[WIDTH-1];
   assign jump_s = is_c_s & ((jmp_s[2] & ng_s) | (jmp_s[1] & zr_s) | (jmp_s[0] & ~ng_s & ~zr_s));

   // Next-state for A, D and PC; the jump target is the A value before this edge
   always_comb begin
      a_d  = a_q;
      d_d  = d_q;
      pc_d = pc_q + PC_W'(1);
      if (!is_c_s || dest_a_s) begin
         a_d = a_src_s;
      end else begin
         a_d = a_q;
      end
      if (is_c_s && dest_d_s) begin
         d_d = alu_r_s;
      end else begin
         d_d = d_q;
      end
      if (jump_s) begin
         pc_d = a_q[PC_W-1:0];
      end else begin
         pc_d = pc_q + PC_W'(1);
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q  <= {WIDTH{1'b0}};
         d_q  <= {WIDTH{1'b0}};
         pc_q <= {PC_W{1'b0}};
      end else begin
         a_q  <= a_d;
         d_q  <= d_d;
         pc_q <= pc_d;
      end
   end

   assign outM     = alu_r_s;
   assign writeM   = is_c_s & dest_m_s & ~reset;
   assign addressM = a_q[PC_W-1:0];
   assign pc       = pc_q;

endmodule
